key_beep_gen: RTL and testbench

KEY_BEEP_GEN -- requirements
Module: key_beep_gen

---
 rtl/key_beep_pkg.sv | 21 ++
 rtl/beep_tone_div.sv | 48 ++++
 rtl/key_beep_gen.sv | 155 +++++++++++++++
 tb/tb_key_beep_gen.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/key_beep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_beep_pkg
// Description : State encoding and default timing constants for key_beep_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package key_beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } beep_state_t;

    localparam int C_KEY_W      = 4;
    localparam int C_TIME_BEEP  = 5000000;
    localparam int C_TIME_GAP   = 5000000;
    localparam int C_TONE_HALF  = 12500;

endpackage
`default_nettype wire

// File: rtl/beep_tone_div.sv
`default_nettype none
// ============================================================================
// Module      : beep_tone_div
// Description : Square-wave tone divider for a passive buzzer; output is low
//               for the first TONE_HALF enabled cycles, and idles high.
// Revision    : 1.0 - initial release
// ============================================================================
module beep_tone_div #(
    parameter int TONE_HALF = 12500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tone_n
);

    localparam int C_PH_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [C_PH_W-1:0] C_PH_LAST = C_PH_W'(TONE_HALF - 1);

    logic [C_PH_W-1:0] r_ph_cnt;
    logic              r_ph;
    logic              r_tone_n;

    // Dropping en restarts the phase so every ON window begins with a low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph_cnt <= '0;
            r_ph     <= 1'b0;
            r_tone_n <= 1'b1;
        end else if (!en) begin
            r_ph_cnt <= '0;
            r_ph     <= 1'b0;
            r_tone_n <= 1'b1;
        end else begin
            r_tone_n <= r_ph;
            if (r_ph_cnt == C_PH_LAST) begin
                r_ph_cnt <= '0;
                r_ph     <= ~r_ph;
            end else begin
                r_ph_cnt <= r_ph_cnt + C_PH_W'(1);
            end
        end
    end

    assign tone_n = r_tone_n;

endmodule
`default_nettype wire

// File: rtl/key_beep_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_beep_gen
// Description : Plays key i as (i+1) beeps with a one-deep pending queue.
//               Define BEEP_TONE_EN for a passive buzzer (toggled tone).
// Revision    : 1.0 - initial release
// ============================================================================
module key_beep_gen
    import key_beep_pkg::*;
#(
    parameter int KEY_W     = C_KEY_W,
    parameter int TIME_BEEP = C_TIME_BEEP,
    parameter int TIME_GAP  = C_TIME_GAP,
    parameter int TONE_HALF = C_TONE_HALF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_vld,
    output logic             buzzer_n,
    output logic             busy,
    output logic             drop
);

    localparam int C_CNT_MAX = (TIME_BEEP > TIME_GAP) ? TIME_BEEP : TIME_GAP;
    localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;
    localparam int C_REM_W   = $clog2(KEY_W + 1);
    localparam logic [C_CNT_W-1:0] C_BEEP_LAST = C_CNT_W'(TIME_BEEP - 1);
    localparam logic [C_CNT_W-1:0] C_GAP_LAST  = C_CNT_W'(TIME_GAP - 1);

    if (KEY_W < 1 || TIME_BEEP < 1 || TIME_GAP < 1 || TONE_HALF < 1) begin : g_param_check
        $error("key_beep_gen: KEY_W and timing parameters must be >= 1");
    end

    beep_state_t        r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_REM_W-1:0] r_remain;
    logic               r_pend_vld;
    logic [C_REM_W-1:0] r_pend_rem;
    logic               r_drop;

    logic               w_trig;
    logic               w_multi;
    logic [C_REM_W-1:0] w_trig_rem;
    logic               w_gap_end;
    logic               w_direct;

    // Lowest set index wins; beep count is index + 1.
    always_comb begin
        w_trig_rem = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (key_vld[i]) begin
                w_trig_rem = C_REM_W'(i + 1);
            end
        end
    end

    assign w_trig    = |key_vld;
    assign w_multi   = |(key_vld & (key_vld - KEY_W'(1)));
    assign w_gap_end = (r_state == ST_GAP) && (r_cnt == C_GAP_LAST);
    assign w_direct  = w_gap_end && (r_remain == '0) && !r_pend_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_remain   <= '0;
            r_pend_vld <= 1'b0;
            r_pend_rem <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= w_multi;
            r_cnt  <= r_cnt + C_CNT_W'(1);

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_trig) begin
                        r_state  <= ST_ON;
                        r_remain <= w_trig_rem;
                    end
                end
                ST_ON: begin
                    if (r_cnt == C_BEEP_LAST) begin
                        r_state  <= ST_GAP;
                        r_cnt    <= '0;
                        r_remain <= r_remain - C_REM_W'(1);
                    end
                end
                ST_GAP: begin
                    if (w_gap_end) begin
                        r_cnt <= '0;
                        if (r_remain != '0) begin
                            r_state <= ST_ON;
                        end else if (r_pend_vld) begin
                            r_state    <= ST_ON;
                            r_remain   <= r_pend_rem;
                            r_pend_vld <= 1'b0;
                        end else if (w_trig) begin
                            r_state  <= ST_ON;
                            r_remain <= w_trig_rem;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase

            // A trigger while busy queues once; a full queue discards it.
            if (w_trig && (r_state != ST_IDLE) && !w_direct) begin
                if (!r_pend_vld) begin
                    r_pend_vld <= 1'b1;
                    r_pend_rem <= w_trig_rem;
                end else begin
                    r_drop <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign drop = r_drop;

`ifdef BEEP_TONE_EN
    logic w_tone_n;

    beep_tone_div #(
        .TONE_HALF (TONE_HALF)
    ) u_tone_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (r_state == ST_ON),
        .tone_n (w_tone_n)
    );

    assign buzzer_n = w_tone_n;
`else
    logic r_buzzer_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buzzer_n <= 1'b1;
        end else begin
            r_buzzer_n <= (r_state != ST_ON);
        end
    end

    assign buzzer_n = r_buzzer_n;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_beep_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_beep_gen
// Description : Directed self-checking bench for key_beep_gen (short timing).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_beep_gen;

    localparam int KEY_W     = 4;
    localparam int TIME_BEEP = 10;
    localparam int TIME_GAP  = 5;
    localparam int TONE_HALF = 2;
    localparam int PER       = TIME_BEEP + TIME_GAP;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic [KEY_W-1:0] key_vld = '0;
    logic             buzzer_n;
    logic             busy;
    logic             drop;

    int n_cmp = 0;
    int n_bad = 0;

    key_beep_gen #(
        .KEY_W     (KEY_W),
        .TIME_BEEP (TIME_BEEP),
        .TIME_GAP  (TIME_GAP),
        .TONE_HALF (TONE_HALF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_vld  (key_vld),
        .buzzer_n (buzzer_n),
        .busy     (busy),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    // Sample j is taken at the falling edge following the j-th rising edge
    // after the first key was captured; the state at sample j is ON for the
    // first TIME_BEEP cycles of every PER-cycle slot.
    function automatic logic on_at(input int j, input int beeps);
        return (j >= 0) && (j < beeps * PER) && ((j % PER) < TIME_BEEP);
    endfunction

    function automatic logic exp_buz(input int j, input int beeps);
        if (!on_at(j - 1, beeps)) return 1'b1;
`ifdef BEEP_TONE_EN
        return ((((j - 1) % PER) / TONE_HALF) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_seq(input string name, input logic [KEY_W-1:0] first, input int beeps,
                           input int drop_at, input int k1_at, input logic [KEY_W-1:0] k1,
                           input int k2_at, input logic [KEY_W-1:0] k2);
        logic e_busy;
        logic e_buz;
        logic e_drop;
        @(negedge clk);
        key_vld = first;
        for (int j = 0; j < beeps * PER + 3; j++) begin
            @(negedge clk);
            key_vld = '0;
            e_busy = (j < beeps * PER);
            e_buz  = exp_buz(j, beeps);
            e_drop = (j == drop_at);
            n_cmp++;
            if (busy !== e_busy) begin
                n_bad++;
                $display("FAIL %s busy[%0d]: got %b want %b", name, j, busy, e_busy);
            end
            n_cmp++;
            if (buzzer_n !== e_buz) begin
                n_bad++;
                $display("FAIL %s buzzer_n[%0d]: got %b want %b", name, j, buzzer_n, e_buz);
            end
            n_cmp++;
            if (drop !== e_drop) begin
                n_bad++;
                $display("FAIL %s drop[%0d]: got %b want %b", name, j, drop, e_drop);
            end
            if (j == k1_at) key_vld = k1;
            if (j == k2_at) key_vld = k2;
        end
    endtask

    task automatic test_reset();
        key_vld = 4'b0001;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (buzzer_n !== 1'b1 || busy !== 1'b0 || drop !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: buzzer_n/busy/drop got %b%b%b want 100", buzzer_n, busy, drop);
        end
        key_vld = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (buzzer_n !== 1'b1 || busy !== 1'b0 || drop !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: buzzer_n/busy/drop got %b%b%b want 100", buzzer_n, busy, drop);
        end
    endtask

    task automatic test_single_key0();
        run_seq("key0", 4'b0001, 1, -1, -1, '0, -1, '0);
    endtask

    task automatic test_key3();
        run_seq("key3", 4'b1000, 4, -1, -1, '0, -1, '0);
    endtask

    task automatic test_multi_bits();
        run_seq("multi", 4'b0110, 2, 0, -1, '0, -1, '0);
    endtask

    // key 2 queues behind key 0, key 3 finds the queue full.
    task automatic test_back_to_back();
        run_seq("b2b", 4'b0001, 4, 6, 2, 4'b0100, 5, 4'b1000);
    endtask

    // Trigger lands on the final gap cycle with nothing queued.
    task automatic test_direct();
        run_seq("direct", 4'b0001, 3, -1, 14, 4'b0010, -1, '0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        key_vld = 4'b1000;
        @(negedge clk);
        key_vld = 4'b0010;
        @(negedge clk);
        key_vld = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (buzzer_n !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_pre: buzzer_n/busy got %b%b want 01", buzzer_n, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (buzzer_n !== 1'b1 || busy !== 1'b0 || drop !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_now: buzzer_n/busy/drop got %b%b%b want 100", buzzer_n, busy, drop);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            n_cmp++;
            if (buzzer_n !== 1'b1 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL arst_after[%0d]: buzzer_n/busy got %b%b want 10", j, buzzer_n, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_key0();
        test_key3();
        test_multi_bits();
        test_back_to_back();
        test_direct();
        test_async_reset();
        test_single_key0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
